// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg
//   Shared types and helpers for the sequential adder/subtractor.
//   - state_e   : controller states (idle, running slices, result pulse)
//   - MODE_*    : encodings of the mode input
//   - cnt_width : slice-counter width for a given slice count (minimum 1)
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A single slice still needs a 1-bit counter so the port widths stay legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_addsub_slice.sv
// slice_adder
//   Combinational CHUNK-bit adder: {cout, sum} = a + b + cin.
//   Ports:
//     a, b  [CHUNK-1:0]  operands
//     cin               carry in
//     sum   [CHUNK-1:0]  low CHUNK bits of the result
//     cout              carry out of the slice
module slice_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

  assign sum  = total[CHUNK-1:0];
  assign cout = total[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub
//   Multi-cycle adder/subtractor. WIDTH-bit operands are processed CHUNK bits
//   per clock, LSB slice first, through one shared slice_adder. A start/done
//   handshake frames each operation; results are registered and only change
//   on entry to the DONE state.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               request, accepted when busy=0 (IDLE or DONE)
//     mode                0 = a+b+cin, 1 = a-b-cin
//     a, b  [WIDTH-1:0]   operands, sampled on the accepting edge
//     cin                 carry-in / borrow-in, sampled on the accepting edge
//     busy                high while slices are being computed
//     done                one-cycle pulse, results valid from this cycle
//     sum   [WIDTH-1:0]   result
//     cout                carry-out (add) / borrow-out (sub)
//     ovf                 two's-complement overflow
//     zero                sum == 0
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("seq_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Controller state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Latched operation; b_q already holds ~b for subtraction and carry_q the
  // inverted borrow, so the datapath is always an addition.
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             mode_q, carry_q;

  // Result registers
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  logic             accept, last_slice;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] res_next;

  assign accept     = start && (state_q != S_RUN);
  assign last_slice = (state_q == S_RUN) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand slice selected by the counter
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  slice_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (c_sl)
  );

  // Partial result with the current slice merged in; on the last slice this is
  // the complete result, so the flags are derived from it in the same cycle.
  always_comb begin
    res_next = res_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        res_next[i*CHUNK +: CHUNK] = s_sl;
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= (mode == MODE_SUB) ? ~b : b;
      mode_q  <= mode;
      carry_q <= (mode == MODE_SUB) ? ~cin : cin;
      res_q   <= '0;
    end else if (state_q == S_RUN) begin
      res_q   <= res_next;
      carry_q <= c_sl;
      if (last_slice) begin
        sum_q  <= res_next;
        cout_q <= (mode_q == MODE_SUB) ? ~c_sl : c_sl;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
        zero_q <= (res_next == '0);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
